// File: rtl/systolic_feeder.sv
// Edge feeder for an NxN systolic multiply array: buffers A and B, then streams
// diagonally skewed operand wavefronts onto the array's left and top edges.
`timescale 1ns / 1ps

module systolic_feeder #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned AW = $clog2(N * N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wr_valid_i,
    output logic            wr_ready_o,
    input  logic            wr_sel_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [DW-1:0]   wr_data_i,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            array_rst_no,
    output logic [N*DW-1:0] left_o,
    output logic [N*DW-1:0] up_o
);

    localparam int unsigned TW = $clog2(2 * N);
    localparam logic [TW-1:0] LastStep  = TW'(2 * N - 2);
    localparam logic [TW-1:0] LastDrain = TW'(N - 2);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;
    logic [TW-1:0] t_q, t_d;

    logic            busy_q;
    logic            done_q;
    logic            arst_n_q;
    logic [N*DW-1:0] left_q, left_d;
    logic [N*DW-1:0] up_q, up_d;

    // Operand storage is deliberately not reset so it survives resets between runs.
    logic [DW-1:0] mem_a [N*N];
    logic [DW-1:0] mem_b [N*N];

    logic addr_ok;
    logic wr_en;

    assign wr_ready_o = (state_q == StIdle);
    assign addr_ok    = ({{(32 - AW){1'b0}}, wr_addr_i} < 32'(N * N));
    assign wr_en      = wr_valid_i && wr_ready_o && addr_ok;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            if (wr_sel_i) begin
                mem_b[wr_addr_i] <= wr_data_i;
            end else begin
                mem_a[wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StStream;
                t_d     = '0;
            end
            StStream: begin
                if (t_q == LastStep) begin
                    state_d = StDrain;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            StDrain: begin
                if (t_q == LastDrain) begin
                    state_d = StDone;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                t_d     = '0;
            end
        endcase
    end

    // Edge operands are precomputed for the step the FSM is about to enter.
    always_comb begin
        int k;
        k      = 0;
        left_d = '0;
        up_d   = '0;
        if (state_d == StStream) begin
            for (int i = 0; i < int'(N); i++) begin
                k = int'(t_d) - i;
                if (k >= 0 && k < int'(N)) begin
                    left_d[i*DW +: DW] = mem_a[AW'(i * int'(N) + k)];
                    up_d[i*DW +: DW]   = mem_b[AW'(k * int'(N) + i)];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            t_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            arst_n_q <= 1'b0;
            left_q   <= '0;
            up_q     <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            busy_q   <= (state_d != StIdle);
            done_q   <= (state_d == StDone);
            arst_n_q <= (state_d != StClear);
            left_q   <= left_d;
            up_q     <= up_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign array_rst_no = arst_n_q;
    assign left_o       = left_q;
    assign up_o         = up_q;

endmodule
